// File: rtl/vc_mem_arb2port.sv
`default_nettype none
// ============================================================================
// vc_mem_arb2port : two-client round-robin memory request arbiter that steers
//                   each memory response back to the client that issued it.
// Revision        : 1.0
// ============================================================================
module vc_mem_arb2port #(
  parameter int ADDR_SZ = 8,
  parameter int DATA_SZ = 32,
  parameter int PTR_SZ  = 2
) (
  input  logic               clk,
  input  logic               reset,

  input  logic               memreq0_bits_rw,
  input  logic [ADDR_SZ-1:0] memreq0_bits_addr,
  input  logic [DATA_SZ-1:0] memreq0_bits_data,
  input  logic               memreq0_val,
  output logic               memreq0_rdy,
  output logic [DATA_SZ-1:0] memresp0_bits_data,
  output logic               memresp0_val,

  input  logic               memreq1_bits_rw,
  input  logic [ADDR_SZ-1:0] memreq1_bits_addr,
  input  logic [DATA_SZ-1:0] memreq1_bits_data,
  input  logic               memreq1_val,
  output logic               memreq1_rdy,
  output logic [DATA_SZ-1:0] memresp1_bits_data,
  output logic               memresp1_val,

  output logic               memreq_bits_rw,
  output logic [ADDR_SZ-1:0] memreq_bits_addr,
  output logic [DATA_SZ-1:0] memreq_bits_data,
  output logic               memreq_val,
  input  logic               memreq_rdy,
  input  logic [DATA_SZ-1:0] memresp_bits_data,
  input  logic               memresp_val,

  output logic               resp_err
);

  localparam int              DEPTH    = 1 << PTR_SZ;
  localparam logic [PTR_SZ:0] FULL_CNT = {1'b1, {PTR_SZ{1'b0}}};

  logic              prio_q, prio_d;
  logic [PTR_SZ-1:0] head_q, head_d;
  logic [PTR_SZ-1:0] tail_q, tail_d;
  logic [PTR_SZ:0]   count_q, count_d;
  logic [DEPTH-1:0]  tags_q, tags_d;
  logic              resp_err_q, resp_err_d;

  logic w_full, w_empty;
  logic w_elig0, w_elig1;
  logic w_gnt_val, w_gnt_port;
  logic w_fire, w_rd_fire;
  logic w_push, w_pop, w_stray;
  logic w_route_val, w_route_port;

  assign w_full  = (count_q == FULL_CNT);
  assign w_empty = (count_q == '0);

  // Writes never need a tag, so only reads are held off by a full FIFO.
  assign w_elig0 = memreq0_val && (memreq0_bits_rw || !w_full);
  assign w_elig1 = memreq1_val && (memreq1_bits_rw || !w_full);

  always_comb begin
    w_gnt_val  = !reset && (w_elig0 || w_elig1);
    w_gnt_port = w_elig1;
    if (w_elig0 && w_elig1) begin
      w_gnt_port = prio_q;
    end
  end

  always_comb begin
    memreq_val       = w_gnt_val;
    memreq_bits_rw   = 1'b0;
    memreq_bits_addr = '0;
    memreq_bits_data = '0;
    if (w_gnt_val) begin
      if (w_gnt_port) begin
        memreq_bits_rw   = memreq1_bits_rw;
        memreq_bits_addr = memreq1_bits_addr;
        memreq_bits_data = memreq1_bits_data;
      end else begin
        memreq_bits_rw   = memreq0_bits_rw;
        memreq_bits_addr = memreq0_bits_addr;
        memreq_bits_data = memreq0_bits_data;
      end
    end
  end

  assign memreq0_rdy = w_gnt_val && !w_gnt_port && memreq_rdy;
  assign memreq1_rdy = w_gnt_val &&  w_gnt_port && memreq_rdy;
  assign w_fire      = w_gnt_val && memreq_rdy;
  assign w_rd_fire   = w_fire && !memreq_bits_rw;

  // An empty FIFO with a same-cycle read models a zero-latency memory.
  always_comb begin
    w_route_val  = 1'b0;
    w_route_port = 1'b0;
    w_pop        = 1'b0;
    w_stray      = 1'b0;
    if (memresp_val && !reset) begin
      if (!w_empty) begin
        w_route_val  = 1'b1;
        w_route_port = tags_q[head_q];
        w_pop        = 1'b1;
      end else if (w_rd_fire) begin
        w_route_val  = 1'b1;
        w_route_port = w_gnt_port;
      end else begin
        w_stray      = 1'b1;
      end
    end
  end

  assign w_push = w_rd_fire && !(w_empty && memresp_val);

  assign memresp0_val       = w_route_val && !w_route_port;
  assign memresp1_val       = w_route_val &&  w_route_port;
  assign memresp0_bits_data = memresp_bits_data;
  assign memresp1_bits_data = memresp_bits_data;
  assign resp_err           = resp_err_q;

  always_comb begin
    prio_d     = w_fire ? !w_gnt_port : prio_q;
    tags_d     = tags_q;
    tail_d     = tail_q;
    head_d     = head_q;
    if (w_push) begin
      tags_d[tail_q] = w_gnt_port;
      tail_d         = tail_q + PTR_SZ'(1);
    end
    if (w_pop) begin
      head_d = head_q + PTR_SZ'(1);
    end
    count_d    = count_q + (PTR_SZ+1)'(w_push) - (PTR_SZ+1)'(w_pop);
    resp_err_d = resp_err_q || w_stray;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q     <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      tags_q     <= '0;
      resp_err_q <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      tags_q     <= tags_d;
      resp_err_q <= resp_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vc_mem_arb2port.sv
`default_nettype none
// ============================================================================
// tb_vc_mem_arb2port : directed vector table, hand sequences and a randomized
//                      run against a queue-based reference model.
// Revision           : 1.0
// ============================================================================
module tb_vc_mem_arb2port;

  localparam int ADDR_SZ = 8;
  localparam int DATA_SZ = 32;
  localparam int PTR_SZ  = 2;
  localparam int DEPTH   = 1 << PTR_SZ;

  logic               clk;
  logic               reset;
  logic               memreq0_bits_rw;
  logic [ADDR_SZ-1:0] memreq0_bits_addr;
  logic [DATA_SZ-1:0] memreq0_bits_data;
  logic               memreq0_val;
  logic               memreq0_rdy;
  logic [DATA_SZ-1:0] memresp0_bits_data;
  logic               memresp0_val;
  logic               memreq1_bits_rw;
  logic [ADDR_SZ-1:0] memreq1_bits_addr;
  logic [DATA_SZ-1:0] memreq1_bits_data;
  logic               memreq1_val;
  logic               memreq1_rdy;
  logic [DATA_SZ-1:0] memresp1_bits_data;
  logic               memresp1_val;
  logic               memreq_bits_rw;
  logic [ADDR_SZ-1:0] memreq_bits_addr;
  logic [DATA_SZ-1:0] memreq_bits_data;
  logic               memreq_val;
  logic               memreq_rdy;
  logic [DATA_SZ-1:0] memresp_bits_data;
  logic               memresp_val;
  logic               resp_err;

  vc_mem_arb2port #(
    .ADDR_SZ(ADDR_SZ),
    .DATA_SZ(DATA_SZ),
    .PTR_SZ (PTR_SZ)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .memreq0_bits_rw   (memreq0_bits_rw),
    .memreq0_bits_addr (memreq0_bits_addr),
    .memreq0_bits_data (memreq0_bits_data),
    .memreq0_val       (memreq0_val),
    .memreq0_rdy       (memreq0_rdy),
    .memresp0_bits_data(memresp0_bits_data),
    .memresp0_val      (memresp0_val),
    .memreq1_bits_rw   (memreq1_bits_rw),
    .memreq1_bits_addr (memreq1_bits_addr),
    .memreq1_bits_data (memreq1_bits_data),
    .memreq1_val       (memreq1_val),
    .memreq1_rdy       (memreq1_rdy),
    .memresp1_bits_data(memresp1_bits_data),
    .memresp1_val      (memresp1_val),
    .memreq_bits_rw    (memreq_bits_rw),
    .memreq_bits_addr  (memreq_bits_addr),
    .memreq_bits_data  (memreq_bits_data),
    .memreq_val        (memreq_val),
    .memreq_rdy        (memreq_rdy),
    .memresp_bits_data (memresp_bits_data),
    .memresp_val       (memresp_val),
    .resp_err          (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        v0;
    logic        rw0;
    logic        v1;
    logic        rw1;
    logic        mrdy;
    logic        rval;
    logic [31:0] rdata;
    logic        e_rdy0;
    logic        e_rdy1;
    logic        e_mval;
    logic [7:0]  e_addr;
    logic        e_rv0;
    logic        e_rv1;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t row(input logic rst, v0, rw0, v1, rw1, mrdy, rval,
                               input logic [31:0] rdata,
                               input logic rdy0, rdy1, mval,
                               input logic [7:0] addr,
                               input logic rv0, rv1, err);
    vec_t v;
    v.rst = rst;     v.v0 = v0;       v.rw0 = rw0;     v.v1 = v1;
    v.rw1 = rw1;     v.mrdy = mrdy;   v.rval = rval;   v.rdata = rdata;
    v.e_rdy0 = rdy0; v.e_rdy1 = rdy1; v.e_mval = mval; v.e_addr = addr;
    v.e_rv0 = rv0;   v.e_rv1 = rv1;   v.e_err = err;
    return v;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Port 0 always targets 0x04, port 1 always targets 0x08 in directed rows.
  task automatic apply_row(input vec_t v, input string nm);
    @(negedge clk);
    reset             = v.rst;
    memreq0_val       = v.v0;
    memreq0_bits_rw   = v.rw0;
    memreq0_bits_addr = 8'h04;
    memreq0_bits_data = 32'h1111_1111;
    memreq1_val       = v.v1;
    memreq1_bits_rw   = v.rw1;
    memreq1_bits_addr = 8'h08;
    memreq1_bits_data = 32'h2222_2222;
    memreq_rdy        = v.mrdy;
    memresp_val       = v.rval;
    memresp_bits_data = v.rdata;
    #1;
    check(nm,
          {memreq0_rdy, memreq1_rdy, memreq_val, memreq_bits_addr,
           memresp0_val, memresp1_val, resp_err},
          {v.e_rdy0, v.e_rdy1, v.e_mval, v.e_addr, v.e_rv0, v.e_rv1, v.e_err});
    check({nm, "_data"}, {memresp0_bits_data, memresp1_bits_data}, {v.rdata, v.rdata});
  endtask

  // Reference model state: outstanding read owners in issue order.
  int   mq[$];
  logic m_tie;
  logic m_err;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        rst v0 rw0 v1 rw1 rdy rval data           r0 r1 mv addr   v0 v1 err
    tbl.push_back(row(0, 1, 0, 0, 0, 1, 0, 32'h0,         1, 0, 1, 8'h04, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 1, 32'hDEADBEEF,  0, 0, 0, 8'h00, 1, 0, 0));
    tbl.push_back(row(1, 1, 0, 1, 0, 1, 1, 32'h0,         0, 0, 0, 8'h00, 0, 0, 0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(row(0, 1, 0, 1, 0, 1, 0, 32'h0, k[0] == 0, k[0] == 1, 1,
                        (k[0] == 0) ? 8'h04 : 8'h08, 0, 0, 0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(row(0, 0, 0, 0, 0, 1, 1, 32'hA000_0000 + k, 0, 0, 0, 8'h00,
                        k[0] == 0, k[0] == 1, 0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(row(0, 1, 0, 1, 0, 0, 0, 32'h0,     0, 0, 1, 8'h04, 0, 0, 0));
    tbl.push_back(row(0, 1, 0, 1, 0, 1, 0, 32'h0,         1, 0, 1, 8'h04, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 1, 32'hB0B0_0001, 0, 0, 0, 8'h00, 1, 0, 0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(row(0, 1, 0, 0, 0, 1, 0, 32'h0,     1, 0, 1, 8'h04, 0, 0, 0));
    tbl.push_back(row(0, 1, 0, 1, 1, 1, 0, 32'h0,         0, 1, 1, 8'h08, 0, 0, 0));
    tbl.push_back(row(0, 1, 0, 0, 0, 1, 1, 32'hC0C0_0000, 0, 0, 0, 8'h00, 1, 0, 0));
    tbl.push_back(row(0, 1, 0, 0, 0, 1, 0, 32'h0,         1, 0, 1, 8'h04, 0, 0, 0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(row(0, 0, 0, 0, 0, 1, 1, 32'hC0C0_0001 + k, 0, 0, 0, 8'h00, 1, 0, 0));
    tbl.push_back(row(0, 0, 0, 1, 0, 1, 1, 32'h12345678,  0, 1, 1, 8'h08, 0, 1, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 1, 32'h5555_AAAA, 0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 1, 32'h0,         0, 0, 0, 8'h00, 0, 0, 1));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 0, 32'h0,         0, 0, 0, 8'h00, 0, 0, 1));
    tbl.push_back(row(1, 0, 0, 0, 0, 1, 0, 32'h0,         0, 0, 0, 8'h00, 0, 0, 1));
    tbl.push_back(row(0, 0, 0, 0, 0, 1, 0, 32'h0,         0, 0, 0, 8'h00, 0, 0, 0));

    reset = 1'b1;
    memreq0_val = 1'b0; memreq0_bits_rw = 1'b0; memreq0_bits_addr = '0; memreq0_bits_data = '0;
    memreq1_val = 1'b0; memreq1_bits_rw = 1'b0; memreq1_bits_addr = '0; memreq1_bits_data = '0;
    memreq_rdy = 1'b0; memresp_val = 1'b0; memresp_bits_data = '0;
    repeat (2) @(negedge clk);

    foreach (tbl[i]) apply_row(tbl[i], $sformatf("row%0d", i));

    // Reset with reads outstanding drops their tags; the late response is stray.
    apply_row(row(0, 1, 0, 0, 0, 1, 0, 32'h0, 1, 0, 1, 8'h04, 0, 0, 0), "midrst_rd0");
    apply_row(row(0, 1, 0, 0, 0, 1, 0, 32'h0, 1, 0, 1, 8'h04, 0, 0, 0), "midrst_rd1");
    apply_row(row(1, 0, 0, 0, 0, 1, 0, 32'h0, 0, 0, 0, 8'h00, 0, 0, 0), "midrst_rst");
    apply_row(row(0, 0, 0, 0, 0, 1, 1, 32'h7, 0, 0, 0, 8'h00, 0, 0, 0), "midrst_resp");
    apply_row(row(0, 0, 0, 0, 0, 1, 0, 32'h0, 0, 0, 0, 8'h00, 0, 0, 1), "midrst_err");

    @(negedge clk);
    reset = 1'b1;
    mq.delete();
    m_tie = 1'b0;
    m_err = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      int   occ;
      logic e0, e1, gv, gp, fire, rdfire, rv0, rv1;
      logic              x_rw;
      logic [ADDR_SZ-1:0] x_addr;
      logic [DATA_SZ-1:0] x_data;

      @(negedge clk);
      reset             = ($urandom_range(0, 149) == 0);
      memreq0_val       = ($urandom_range(0, 3) != 0);
      memreq0_bits_rw   = ($urandom_range(0, 2) == 0);
      memreq0_bits_addr = 8'($urandom);
      memreq0_bits_data = $urandom;
      memreq1_val       = ($urandom_range(0, 3) != 0);
      memreq1_bits_rw   = ($urandom_range(0, 2) == 0);
      memreq1_bits_addr = 8'($urandom);
      memreq1_bits_data = $urandom;
      memreq_rdy        = ($urandom_range(0, 3) != 0);
      memresp_val       = ($urandom_range(0, 9) < 4);
      memresp_bits_data = $urandom;
      #1;

      occ = mq.size();
      e0  = memreq0_val && (memreq0_bits_rw || occ < DEPTH);
      e1  = memreq1_val && (memreq1_bits_rw || occ < DEPTH);
      gv  = !reset && (e0 || e1);
      gp  = (e0 && e1) ? m_tie : e1;
      x_rw = 1'b0; x_addr = '0; x_data = '0;
      if (gv) begin
        x_rw   = gp ? memreq1_bits_rw   : memreq0_bits_rw;
        x_addr = gp ? memreq1_bits_addr : memreq0_bits_addr;
        x_data = gp ? memreq1_bits_data : memreq0_bits_data;
      end
      fire   = gv && memreq_rdy;
      rdfire = fire && !x_rw;
      rv0 = 1'b0;
      rv1 = 1'b0;
      if (!reset && memresp_val) begin
        if (occ > 0) begin
          rv0 = (mq[0] == 0);
          rv1 = (mq[0] == 1);
        end else if (rdfire) begin
          rv0 = !gp;
          rv1 = gp;
        end
      end

      check($sformatf("rand%0d", c),
            {memreq0_rdy, memreq1_rdy, memreq_val, memreq_bits_rw, memreq_bits_addr,
             memreq_bits_data, memresp0_val, memresp1_val, resp_err},
            {fire && !gp, fire && gp, gv, x_rw, x_addr, x_data, rv0, rv1, m_err});

      if (reset) begin
        mq.delete();
        m_tie = 1'b0;
        m_err = 1'b0;
      end else begin
        if (memresp_val && occ > 0) void'(mq.pop_front());
        if (memresp_val && occ == 0 && !rdfire) m_err = 1'b1;
        if (rdfire && !(occ == 0 && memresp_val)) mq.push_back(int'(gp));
        if (fire) m_tie = !gp;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
